// File: rtl/char_rx_buffer_pkg.sv
// Shared types and helpers for the serial character receiver and its display buffer.
package char_rx_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Data is zero-extended by the caller; extra zeros do not change the XOR.
  function automatic logic parity_ok(input logic [63:0] data, input logic pbit, input logic odd);
    return ((^data) ^ pbit) == odd;
  endfunction

endpackage

// File: rtl/char_rx_buffer_if.sv
// Serial input, clear strobe and display-buffer outputs of the character receiver.
interface char_rx_buffer_if
  import char_rx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 26
);
  localparam int CNT_W = count_width(DEPTH);

  logic                      rx_i;
  logic                      clr_i;
  logic [DEPTH*DATA_W-1:0]   chars_o;
  logic [CNT_W-1:0]          count_o;
  logic [DATA_W-1:0]         char_o;
  logic                      char_valid_o;
  logic                      frame_err_o;
  logic                      par_err_o;
  logic                      overflow_o;

  modport master (
    output rx_i, clr_i,
    input  chars_o, count_o, char_o, char_valid_o, frame_err_o, par_err_o, overflow_o
  );

  modport slave (
    input  rx_i, clr_i,
    output chars_o, count_o, char_o, char_valid_o, frame_err_o, par_err_o, overflow_o
  );

endinterface

// File: rtl/char_rx_buffer_deframer.sv
// Start/data/parity/stop deframer with mid-bit oversampled sampling and frame checks.
module char_rx_deframer
  import char_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic              cclk,
  input  logic              rstb,
  input  logic              rx,
  output logic [DATA_W-1:0] data,
  output logic              take,
  output logic              accept,
  output logic              frame_err,
  output logic              par_err
);
  localparam int HALF  = (BIT_CYCLES - 1) / 2;
  localparam int CNT_W = $clog2(BIT_CYCLES + 1);
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);

  rx_state_t         state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [DATA_W-1:0] data_reg;
  logic              par_reg;
  logic              accept_reg;
  logic              ferr_reg;
  logic              perr_reg;
  logic              sample;
  logic              par_good;

  // cnt_reg counts down the cycles left before the next mid-bit sample.
  assign sample   = (cnt_reg == '0);
  assign par_good = (PARITY_EN == 0) || parity_ok(64'(data_reg), par_reg, PARITY_ODD != 0);
  assign take     = (state_reg == STOP) && sample && rx && par_good;

  always_ff @(posedge cclk or posedge rstb) begin
    if (rstb) begin
      state_reg  <= WAIT_IDLE;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      data_reg   <= '0;
      par_reg    <= 1'b0;
      accept_reg <= 1'b0;
      ferr_reg   <= 1'b0;
      perr_reg   <= 1'b0;
    end else begin
      accept_reg <= 1'b0;
      ferr_reg   <= 1'b0;
      perr_reg   <= 1'b0;
      case (state_reg)
        WAIT_IDLE: if (rx) state_reg <= IDLE;
        IDLE: begin
          if (!rx) begin
            // With one cycle per bit the falling edge itself is the start check.
            if (HALF == 0) begin
              state_reg <= DATA;
              cnt_reg   <= BIT_LOAD;
              idx_reg   <= '0;
            end else begin
              state_reg <= START;
              cnt_reg   <= HALF_LOAD;
            end
          end
        end
        START: begin
          if (!sample) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else if (rx) begin
            state_reg <= IDLE;
          end else begin
            state_reg <= DATA;
            cnt_reg   <= BIT_LOAD;
            idx_reg   <= '0;
          end
        end
        DATA: begin
          if (!sample) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            data_reg <= {rx, data_reg[DATA_W-1:1]};
            cnt_reg  <= BIT_LOAD;
            if (idx_reg == LAST_IDX) state_reg <= (PARITY_EN != 0) ? PARITY : STOP;
            else idx_reg <= idx_reg + 1'b1;
          end
        end
        PARITY: begin
          if (!sample) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            par_reg   <= rx;
            cnt_reg   <= BIT_LOAD;
            state_reg <= STOP;
          end
        end
        STOP: begin
          if (!sample) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else if (!rx) begin
            ferr_reg  <= 1'b1;
            state_reg <= WAIT_IDLE;
          end else if (!par_good) begin
            perr_reg  <= 1'b1;
            state_reg <= IDLE;
          end else begin
            accept_reg <= 1'b1;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= WAIT_IDLE;
      endcase
    end
  end

  assign data      = data_reg;
  assign accept    = accept_reg;
  assign frame_err = ferr_reg;
  assign par_err   = perr_reg;

endmodule

// File: rtl/char_rx_buffer.sv
// Serial character receiver feeding a scrolling/saturating display buffer.
module char_rx_buffer
  import char_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 26,
  parameter int BIT_CYCLES = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int SCROLL     = 1
) (
  input logic             cclk,
  input logic             rstb,
  char_rx_buffer_if.slave bus
);
  localparam int CNT_W = count_width(DEPTH);

  logic [DATA_W-1:0]       data;
  logic                    take;
  logic                    accept;
  logic                    frame_err;
  logic                    par_err;
  logic [CNT_W-1:0]        count_reg;
  logic [DATA_W-1:0]       char_reg;
  logic                    valid_reg;
  logic                    ferr_reg;
  logic                    perr_reg;
  logic                    ovf_reg;
  logic                    full;
  logic [DEPTH*DATA_W-1:0] chars;

  char_rx_deframer #(
    .DATA_W    (DATA_W),
    .BIT_CYCLES(BIT_CYCLES),
    .PARITY_EN (PARITY_EN),
    .PARITY_ODD(PARITY_ODD)
  ) u_deframer (
    .cclk     (cclk),
    .rstb     (rstb),
    .rx       (bus.rx_i),
    .data     (data),
    .take     (take),
    .accept   (accept),
    .frame_err(frame_err),
    .par_err  (par_err)
  );

  assign full = (count_reg == CNT_W'(DEPTH));

  // Buffer/char_o follow the stop-sample edge; the status pulses trail by one cycle.
  always_ff @(posedge cclk or posedge rstb) begin
    if (rstb) begin
      count_reg <= '0;
      char_reg  <= '0;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
      perr_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      valid_reg <= accept;
      ferr_reg  <= frame_err;
      perr_reg  <= par_err;
      if (take) char_reg <= data;
      if (bus.clr_i) begin
        count_reg <= '0;
        ovf_reg   <= 1'b0;
      end else if (take) begin
        if (full) ovf_reg <= 1'b1;
        else count_reg <= count_reg + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [DATA_W-1:0] slot_reg;
    logic [DATA_W-1:0] up;

    // On a full scroll each slot takes its upper neighbour; the top slot takes the new char.
    if (gi == DEPTH - 1) begin : g_top
      assign up = data;
    end else begin : g_mid
      assign up = chars[(gi+1)*DATA_W +: DATA_W];
    end

    always_ff @(posedge cclk or posedge rstb) begin
      if (rstb) begin
        slot_reg <= '0;
      end else if (bus.clr_i) begin
        slot_reg <= '0;
      end else if (take) begin
        if (count_reg == CNT_W'(gi)) slot_reg <= data;
        else if (full && (SCROLL != 0)) slot_reg <= up;
      end
    end

    assign chars[gi*DATA_W +: DATA_W] = slot_reg;
  end

  assign bus.chars_o      = chars;
  assign bus.count_o      = count_reg;
  assign bus.char_o       = char_reg;
  assign bus.char_valid_o = valid_reg;
  assign bus.frame_err_o  = ferr_reg;
  assign bus.par_err_o    = perr_reg;
  assign bus.overflow_o   = ovf_reg;

endmodule
